// File: rtl/reram_pulse_sequencer.sv
// reram_pulse_sequencer: Wishbone-mapped READ/SET/RESET pulse sequencer for one ReRAM crossbar cell.
// Optional verify-after-write with bounded retries is enabled by defining RERAM_VERIFY_EN.
module reram_pulse_sequencer #(
    parameter int          ROWS      = 8,
    parameter int          COLS      = 8,
    parameter int          SETUP_CYC = 2,
    parameter int          HOLD_CYC  = 2,
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
    parameter int          MAX_RETRY = 3
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic [ROWS-1:0] row_en,
    output logic [COLS-1:0] col_en,
    output logic            drive_set,
    output logic            drive_reset,
    output logic            sense_en,
    input  logic            sense_in,
    output logic            irq
);
    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, HOLD, DONE
`ifdef RERAM_VERIFY_EN
        , VSETUP, VSENSE
`endif
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, reload, pw, pw_run;
    logic [7:0]  row, col, row_run, col_run, row_new, col_new;
    logic [1:0]  op, op_run, op_new;
    logic [3:0]  retries;
    logic        done, err, result, go, busy, acc, sel, vsense, vfail, bad, sample;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[30:24]};
    assign acc = wbs_cyc_i && wbs_stb_i && wbs_adr_i[31:4] == BASE_ADR[31:4] && !wbs_ack_o;
    assign busy = state != IDLE;
    assign op_new = wbs_sel_i[0] ? wbs_dat_i[1:0] : op;
    assign row_new = wbs_sel_i[1] ? wbs_dat_i[15:8] : row;
    assign col_new = wbs_sel_i[2] ? wbs_dat_i[23:16] : col;
    assign bad = op_new == 2'd3 || int'(row_new) >= ROWS || int'(col_new) >= COLS;
    assign sample = cnt == 16'd0 && ((state == PULSE && op_run == 2'd0) || vsense);

`ifdef RERAM_VERIFY_EN
    assign vsense = state == VSENSE;
    assign vfail = vsense && cnt == 16'd0 && sense_in != (op_run == 2'd1);
`else
    assign vsense = 1'b0;
    assign vfail = 1'b0;
`endif

    // Register read mux
    always_comb begin
        rdata = '0;
        if (wbs_adr_i[3:2] == 2'd0) rdata = {8'd0, col, row, 6'd0, op};
        else if (wbs_adr_i[3:2] == 2'd1) rdata = {16'd0, pw};
        else if (wbs_adr_i[3:2] == 2'd2) rdata = {24'd0, retries, err, result, done, busy};
    end

    // Wishbone slave, configuration/status registers and start acceptance
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            op <= '0;
            row <= '0;
            col <= '0;
            pw <= 16'd10;
            done <= 1'b0;
            err <= 1'b0;
            result <= 1'b0;
            go <= 1'b0;
            op_run <= '0;
            row_run <= '0;
            col_run <= '0;
            pw_run <= 16'd1;
            retries <= '0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= acc && !wbs_we_i ? rdata : '0;
            go <= 1'b0;
            if (acc && wbs_we_i && wbs_adr_i[3:2] == 2'd0) begin
                op <= op_new;
                row <= row_new;
                col <= col_new;
                if (wbs_sel_i[3] && wbs_dat_i[31]) begin
                    if (busy || go || bad) err <= 1'b1;
                    else begin
                        go <= 1'b1;
                        op_run <= op_new;
                        row_run <= row_new;
                        col_run <= col_new;
                        pw_run <= pw == 16'd0 ? 16'd1 : pw;
                        retries <= '0;
                    end
                end
            end
            if (acc && wbs_we_i && wbs_adr_i[3:2] == 2'd1) begin
                if (wbs_sel_i[0]) pw[7:0] <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) pw[15:8] <= wbs_dat_i[15:8];
            end
            if (acc && wbs_we_i && wbs_adr_i[3:2] == 2'd2 && wbs_sel_i[0]) begin
                if (wbs_dat_i[1]) done <= 1'b0;
                if (wbs_dat_i[3]) err <= 1'b0;
            end
            if (state_n == DONE) done <= 1'b1;
            if (sample) result <= sense_in;
            if (vfail && int'(retries) < MAX_RETRY) retries <= retries + 4'd1;
            if (vfail && int'(retries) >= MAX_RETRY) err <= 1'b1;
        end
    end

    // State register and per-state down-counter, reloaded on every state entry
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= state_n != state ? reload : cnt != 16'd0 ? cnt - 16'd1 : cnt;
        end
    end

    // Next-state, counter reload and crossbar drive decode
    always_comb begin
        state_n = state;
        reload = '0;
        case (state)
            IDLE:  if (go) state_n = SETUP;
            SETUP: if (cnt == 16'd0) state_n = PULSE;
            PULSE: if (cnt == 16'd0) state_n = HOLD;
`ifdef RERAM_VERIFY_EN
            HOLD:   if (cnt == 16'd0) state_n = op_run == 2'd0 ? DONE : VSETUP;
            VSETUP: if (cnt == 16'd0) state_n = VSENSE;
            VSENSE: if (cnt == 16'd0) state_n = vfail && int'(retries) < MAX_RETRY ? SETUP : DONE;
`else
            HOLD:  if (cnt == 16'd0) state_n = DONE;
`endif
            default: state_n = IDLE;
        endcase
        if (state_n == SETUP) reload = 16'(SETUP_CYC - 1);
        if (state_n == PULSE) reload = pw_run - 16'd1;
        if (state_n == HOLD) reload = 16'(HOLD_CYC - 1);
`ifdef RERAM_VERIFY_EN
        if (state_n == VSETUP) reload = 16'(SETUP_CYC - 1);
        if (state_n == VSENSE) reload = pw_run - 16'd1;
`endif
        sel = state != IDLE && state != DONE;
        row_en = sel ? {{(ROWS-1){1'b0}}, 1'b1} << row_run : '0;
        col_en = sel ? {{(COLS-1){1'b0}}, 1'b1} << col_run : '0;
        drive_set = state == PULSE && op_run == 2'd1;
        drive_reset = state == PULSE && op_run == 2'd2;
        sense_en = (state == PULSE && op_run == 2'd0) || vsense;
        irq = state == DONE;
    end
endmodule

// File: tb/tb_reram_pulse_sequencer.sv
// tb_reram_pulse_sequencer: directed self-checking bench for reram_pulse_sequencer.
module tb_reram_pulse_sequencer;
    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef RERAM_VERIFY_EN
    localparam int SET_LAT = 17;
    localparam logic [31:0] SET_ST = 32'h6;
`else
    localparam int SET_LAT = 10;
    localparam logic [31:0] SET_ST = 32'h2;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, sense_in = 1'b1;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_w = '0, dat_r, rd;
    logic        ack, drive_set, drive_reset, sense_en, irq;
    logic [7:0]  row_en, col_en;
    int          checks = 0, errors = 0, ncnt = 0, ds_cnt = 0, t_ack = 0, t0, ds_base;

    reram_pulse_sequencer dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
        .row_en(row_en), .col_en(col_en), .drive_set(drive_set), .drive_reset(drive_reset),
        .sense_en(sense_en), .sense_in(sense_in), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncnt <= ncnt + 1;
    always @(negedge clk) if (drive_set) ds_cnt <= ds_cnt + 1;

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = a; dat_w = d; sel = s;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) break;
        end
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL wr_ack adr=%h got ack=%b want 1", a, ack); end
        t_ack = ncnt;
        cyc = 0; stb = 0; we = 0; sel = 0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hf;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) break;
        end
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL rd_ack adr=%h got ack=%b want 1", a, ack); end
        d = dat_r;
        cyc = 0; stb = 0;
    endtask

    task automatic wait_irq(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (irq) break;
        end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_timeout got irq=%b want 1", irq); end
    endtask

    task automatic test_reset;
        rst = 1; sense_in = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({row_en, col_en, drive_set, drive_reset, sense_en, irq, ack} !== '0)
            begin errors++; $display("FAIL reset_outs got %h_%h_%b%b%b%b%b want 0", row_en, col_en, drive_set, drive_reset, sense_en, irq, ack); end
        checks++;
        if (dat_r !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 0", dat_r); end
        rst = 0;
        wb_read(BASE + 4, rd);
        checks++;
        if (rd !== 32'd10) begin errors++; $display("FAIL reset_pw got %0d want 10", rd); end
        wb_read(BASE + 8, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", rd); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = BASE + 4; sel = 4'hf;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (ack !== (k % 2 == 0) || dat_r !== ((k % 2 == 0) ? 32'd10 : 32'd0))
                begin errors++; $display("FAIL b2b k=%0d got ack=%b dat=%h want ack=%b", k, ack, dat_r, k % 2 == 0); end
        end
        adr = BASE + 32'h10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0) begin errors++; $display("FAIL out_of_range k=%0d got ack=%b want 0", k, ack); end
        end
        cyc = 0; stb = 0;
    endtask

    task automatic test_set;
        wb_write(BASE + 4, 32'd5, 4'h3);
        ds_base = ds_cnt;
        wb_write(BASE, 32'h8003_0201, 4'hf);
        t0 = t_ack;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if ({row_en, col_en, drive_set, drive_reset, sense_en, irq} !== {8'h04, 8'h08, k >= 3 && k <= 7, 3'b000})
                begin errors++; $display("FAIL set_cyc k=%0d got row=%h col=%h ds=%b dr=%b se=%b irq=%b", k, row_en, col_en, drive_set, drive_reset, sense_en, irq); end
        end
        wait_irq(40);
        checks++;
        if (ncnt - t0 !== SET_LAT) begin errors++; $display("FAIL set_latency got %0d want %0d", ncnt - t0, SET_LAT); end
        @(negedge clk);
        checks++;
        if (ds_cnt - ds_base !== 5 || row_en !== 8'h0)
            begin errors++; $display("FAIL set_pulse got drive cycles=%0d row=%h want 5 and 0", ds_cnt - ds_base, row_en); end
        wb_read(BASE + 8, rd);
        checks++;
        if (rd !== SET_ST) begin errors++; $display("FAIL set_status got %h want %h", rd, SET_ST); end
        wb_write(BASE + 8, 32'hA, 4'h1);
    endtask

    task automatic test_read;
        sense_in = 1;
        wb_write(BASE, 32'h8000_0700, 4'hf);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if ({row_en, col_en, drive_set, drive_reset, sense_en, irq} !==
                {k <= 9 ? 8'h80 : 8'h00, k <= 9 ? 8'h01 : 8'h00, 2'b00, k >= 3 && k <= 7, k == 10})
                begin errors++; $display("FAIL read_cyc k=%0d got row=%h col=%h ds=%b dr=%b se=%b irq=%b", k, row_en, col_en, drive_set, drive_reset, sense_en, irq); end
        end
        wb_read(BASE + 8, rd);
        checks++;
        if (rd !== 32'h6) begin errors++; $display("FAIL read_status got %h want 6", rd); end
        wb_write(BASE + 8, 32'hA, 4'h1);
    endtask

    task automatic test_bad_start;
        wb_write(BASE, 32'h8000_0801, 4'hf);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({row_en, col_en, drive_set, sense_en} !== '0) begin errors++; $display("FAIL bad_row_idle k=%0d got row=%h col=%h", k, row_en, col_en); end
        end
        wb_read(BASE + 8, rd);
        checks++;
        if (rd !== 32'hC) begin errors++; $display("FAIL bad_row_status got %h want c", rd); end
        wb_write(BASE + 8, 32'h8, 4'h1);
        wb_read(BASE + 8, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL err_clear got %h want 4", rd); end
        wb_write(BASE, 32'h8000_0003, 4'hf);
        repeat (3) @(negedge clk);
        checks++;
        if ({row_en, col_en} !== '0) begin errors++; $display("FAIL bad_op_idle got row=%h col=%h want 0", row_en, col_en); end
        wb_read(BASE + 8, rd);
        checks++;
        if (rd !== 32'hC) begin errors++; $display("FAIL bad_op_status got %h want c", rd); end
        wb_write(BASE + 8, 32'h8, 4'h1);
    endtask

    task automatic test_busy_start;
        ds_base = ds_cnt;
        wb_write(BASE, 32'h8003_0201, 4'hf);
        t0 = t_ack;
        repeat (2) @(negedge clk);
        wb_write(BASE, 32'h8000_0000, 4'hf);
        wait_irq(40);
        checks++;
        if (ncnt - t0 !== SET_LAT) begin errors++; $display("FAIL busy_latency got %0d want %0d", ncnt - t0, SET_LAT); end
        repeat (12) @(negedge clk);
        checks++;
        if (ds_cnt - ds_base !== 5 || {row_en, sense_en} !== '0)
            begin errors++; $display("FAIL busy_unaltered got drive cycles=%0d row=%h se=%b want 5,0,0", ds_cnt - ds_base, row_en, sense_en); end
        wb_read(BASE + 8, rd);
        checks++;
        if (rd !== 32'hE) begin errors++; $display("FAIL busy_status got %h want e", rd); end
        wb_write(BASE + 8, 32'hA, 4'h1);
    endtask

    task automatic test_reset_mid_pulse;
        wb_write(BASE, 32'h8001_0102, 4'hf);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (drive_reset) break;
        end
        checks++;
        if (drive_reset !== 1'b1 || row_en !== 8'h02) begin errors++; $display("FAIL reset_pulse_seen got dr=%b row=%h want 1,02", drive_reset, row_en); end
        #1 rst = 1;
        #1;
        checks++;
        if ({drive_reset, row_en, col_en} !== '0) begin errors++; $display("FAIL async_drop got dr=%b row=%h col=%h want 0", drive_reset, row_en, col_en); end
        @(negedge clk);
        rst = 0;
        wb_read(BASE + 4, rd);
        checks++;
        if (rd !== 32'd10) begin errors++; $display("FAIL rst_pw got %0d want 10", rd); end
        wb_read(BASE + 8, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rst_status got %h want 0", rd); end
    endtask

`ifdef RERAM_VERIFY_EN
    task automatic test_verify;
        sense_in = 0;
        wb_write(BASE, 32'h8000_0001, 4'hf);
        wait_irq(300);
        wb_read(BASE + 8, rd);
        checks++;
        if (rd !== 32'h3A) begin errors++; $display("FAIL verify_status got %h want 3a", rd); end
        sense_in = 1;
    endtask
`endif

    initial begin
        test_reset;
        test_back_to_back;
        test_set;
        test_read;
        test_bad_start;
        test_busy_start;
        test_reset_mid_pulse;
`ifdef RERAM_VERIFY_EN
        test_verify;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reram_pulse_sequencer.md
Name: reram_pulse_sequencer

Overview:
- Wishbone-mapped controller that sequences single-cell READ, SET and RESET operations on the ReRAM crossbar array.
- Software writes the row/column address, the operation and the pulse width. The block then runs select → pulse → sense → release timing on the crossbar row/column enables and drive strobes.
- Sits in the user analog project wrapper between the management SoC Wishbone bus and the crossbar analog periphery. Raises an IRQ on completion.

Parameters:
- ROWS, 8, number of crossbar word lines (one-hot row_en width), 2..256
- COLS, 8, number of crossbar bit lines (one-hot col_en width), 2..256
- SETUP_CYC, 2, cycles selects are held before any drive strobe, ≥1
- HOLD_CYC, 2, cycles selects are held after the drive strobe drops, ≥1
- BASE_ADR, 32'h3000_0000, Wishbone base address; decode uses wbs_adr_i[31:4]
- MAX_RETRY, 3, verify retry limit, used only with the optional feature

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects; register fields are written only where the byte is selected
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- row_en  out  ROWS  one-hot word-line select
- col_en  out  COLS  one-hot bit-line select
- drive_set  out  1  SET pulse strobe to the bit-line driver
- drive_reset  out  1  RESET pulse strobe
- sense_en  out  1  read-bias and sense-amp enable
- sense_in  in  1  sense-amp comparator output; synchronous to wb_clk_i; 1 = low-resistance state
- irq  out  1  one-cycle completion pulse

Behaviour:
- Interface decision: one clock, wb_clk_i; reset wb_rst_i is asynchronous and active-high.
- Register map (byte offset from BASE_ADR):
  - 0x0 CTRL: [1:0] op (0 = READ, 1 = SET, 2 = RESET, 3 = illegal), [15:8] row, [23:16] col, [31] start (write-only, self-clearing, reads 0).
  - 0x4 PW: [15:0] pulse-width cycles; reset value 10; a value of 0 is treated as 1.
  - 0x8 STATUS:
    - [0] busy, read-only
    - [1] done, write-1-to-clear
    - [2] result, last sensed bit
    - [3] err, write-1-to-clear
    - [7:4] retries used
  - 0xC: reads 0, writes ignored.
- Wishbone timing:
  - wbs_ack_o asserts exactly one cycle after cyc&stb&address-hit and is held for one cycle only.
  - No ack while the previous ack is high, so back-to-back accesses get one idle cycle between acks.
  - wbs_dat_o is valid while ack is high and 0 otherwise.
  - Accesses outside BASE_ADR are not acked.
- Start rules:
  - A write of start=1 while idle launches the operation.
  - If op=3, row ≥ ROWS or col ≥ COLS, the start is rejected: err=1, no FSM transition.
  - A start while busy is ignored and sets err=1; the running operation is unaffected.
- FSM states: IDLE → SETUP → PULSE → HOLD → DONE → IDLE.
  - IDLE: all outputs 0.
  - SETUP, SETUP_CYC cycles: row_en/col_en one-hot at the latched address; strobes 0.
  - PULSE, PW cycles: exactly one of drive_set / drive_reset / sense_en high, chosen by op. For READ, sense_in is sampled into result on the last PULSE cycle.
  - HOLD, HOLD_CYC cycles: strobes 0, selects still asserted.
  - DONE, 1 cycle: selects 0, done=1, irq=1 for this cycle only.
- busy = (state ≠ IDLE). It rises the cycle after the accepted start write is acked.
- Total latency from start ack to irq: SETUP_CYC + PW + HOLD_CYC + 1 cycles.
- Safety invariants:
  - At most one of drive_set, drive_reset, sense_en is high in any cycle.
  - No strobe is ever high unless exactly one row_en bit and exactly one col_en bit are high.
- Counters: 16-bit down-counter reloaded at each state entry.
- A PW write during an operation takes effect on the next start; the op, row, col and PW values are latched at start.
- Reset mid-operation drops all outputs to 0 asynchronously. After reset: FSM in IDLE, PW=10, STATUS=0, wbs_ack_o=0, wbs_dat_o=0, irq=0.

Optional Feature:
- Macro: RERAM_VERIFY_EN.
- When defined, SET and RESET operations append a verify read after HOLD: VSETUP (SETUP_CYC) → VSENSE (PW cycles, sense_en, sample on the last cycle).
- Pass condition: sense_in=1 for SET, 0 for RESET.
- On pass: go to DONE.
- On fail: if retries < MAX_RETRY, increment STATUS[7:4] and return to SETUP to re-pulse. Otherwise set err=1 and go to DONE.
- When undefined: no verify states exist and STATUS[7:4] reads 0.

Test Plan:
- Reset with sense_in=1 → all outputs 0; a read of 0x4 returns 10; a read of 0x8 returns 0.
- PW=5, CTRL={start, col=3, row=2, op=SET} → row_en=8'h04 and col_en=8'h08 for 2 cycles, then drive_set high for exactly 5 cycles, hold for 2 cycles; irq fires 10 cycles after the ack; STATUS=0x2.
- READ at row 7, col 0 with sense_in=1 during PULSE → sense_en high for PW cycles, never overlapping drive_*; STATUS[2]=1.
- Start with row=8, or op=3 → no FSM activity, err=1; a write of 0x8 to STATUS clears err.
- Start written 3 cycles into a running SET → ignored, err=1; the original operation completes unaltered.
- wb_rst_i asserted mid-PULSE → drive_reset and row_en drop in the same cycle. With RERAM_VERIFY_EN defined, SET with sense_in stuck at 0 → 3 retries, STATUS[7:4]=3, err=1.
